// File: rtl/servo_pwm_driver_pkg.sv
// Shared definitions for the arm servo path: position limits, PWM FSM state
// encoding and the command clamp used by both the channels and the settled compare.
package brazo_pkg;

    localparam int unsigned POS_MAX   = 100;
    localparam int unsigned POS_RESET = 50;

    typedef enum logic {
        PWM_OFF = 1'b0,
        PWM_RUN = 1'b1
    } pwm_state_t;

    function automatic logic [7:0] clamp_pos(input logic [7:0] pos, input logic [7:0] limit);
        return (pos > limit) ? limit : pos;
    endfunction

endpackage

// File: rtl/servo_pwm_driver_if.sv
// Command/status bundle between the mode-select FSM side and the servo PWM driver.
interface servo_pwm_driver_if;

    logic       enable;
    logic [7:0] pos_x;
    logic [7:0] pos_y;
    logic [7:0] pos_z;
    logic       pwm_x;
    logic       pwm_y;
    logic       pwm_z;
    logic [7:0] cur_x;
    logic [7:0] cur_y;
    logic [7:0] cur_z;
    logic       frame_start;
    logic       settled;

    modport master (
        output enable, pos_x, pos_y, pos_z,
        input  pwm_x, pwm_y, pwm_z, cur_x, cur_y, cur_z, frame_start, settled
    );

    modport slave (
        input  enable, pos_x, pos_y, pos_z,
        output pwm_x, pwm_y, pwm_z, cur_x, cur_y, cur_z, frame_start, settled
    );

endinterface

// File: rtl/servo_pwm_driver_channel.sv
// One servo axis: clamps the command, slews the output position once per frame
// and compares the microsecond counter against the resulting pulse width.
module servo_channel #(
    parameter int unsigned MIN_PULSE_US = 1000,
    parameter int unsigned US_PER_STEP  = 10,
    parameter int unsigned POS_MAX      = brazo_pkg::POS_MAX,
    parameter int unsigned POS_RESET    = brazo_pkg::POS_RESET,
    parameter int unsigned MAX_STEP     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_end,
    input  logic        run,
    input  logic [15:0] us_cnt,
    input  logic [7:0]  pos,
    output logic        pwm,
    output logic [7:0]  cur
);
    import brazo_pkg::*;

    logic [7:0]        cur_q;
    logic              pwm_q;
    logic [7:0]        tgt;
    logic signed [8:0] diff;
    logic [7:0]        nxt;
    logic [15:0]       width;

    always_comb begin
        tgt   = clamp_pos(pos, 8'(POS_MAX));
        diff  = $signed({1'b0, tgt}) - $signed({1'b0, cur_q});
        nxt   = tgt;
        if (diff > $signed(9'(MAX_STEP))) begin
            nxt = cur_q + 8'(MAX_STEP);
        end else if (diff < -$signed(9'(MAX_STEP))) begin
            nxt = cur_q - 8'(MAX_STEP);
        end
        width = 16'(MIN_PULSE_US) + 16'(cur_q) * 16'(US_PER_STEP);
    end

    // cur only moves on the frame_end edge, so a new width starts at us_cnt 0
    always_ff @(posedge clk) begin
        if (!rst) begin
            cur_q <= 8'(POS_RESET);
            pwm_q <= 1'b0;
        end else begin
            if (frame_end) begin
                cur_q <= nxt;
            end
            pwm_q <= run && (us_cnt < width);
        end
    end

    assign pwm = pwm_q;
    assign cur = cur_q;

endmodule

// File: rtl/servo_pwm_driver.sv
// Three-axis hobby-servo PWM driver: microsecond timebase, OFF/RUN frame FSM,
// per-axis slewed channels and the all-axes settled flag.
module servo_pwm_driver #(
    parameter int unsigned CLK_HZ       = 50_000_000,
    parameter int unsigned FRAME_US     = 20000,
    parameter int unsigned MIN_PULSE_US = 1000,
    parameter int unsigned US_PER_STEP  = 10,
    parameter int unsigned POS_MAX      = brazo_pkg::POS_MAX,
    parameter int unsigned POS_RESET    = brazo_pkg::POS_RESET,
    parameter int unsigned MAX_STEP     = 2
) (
    input  logic               clk,
    input  logic               rst,
    servo_pwm_driver_if.slave  bus
);
    import brazo_pkg::*;

    localparam int unsigned DIV = CLK_HZ / 1_000_000;
    localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;

    pwm_state_t  state;
    logic [PW-1:0] presc;
    logic [15:0] us_cnt;
    logic        fs_q;
    logic        run;
    logic        us_tick;
    logic        frame_end;
    logic        pwm_x, pwm_y, pwm_z;
    logic [7:0]  cur_x, cur_y, cur_z;

    assign run       = (state == PWM_RUN);
    assign us_tick   = run && (presc == PW'(DIV - 1));
    assign frame_end = us_tick && (us_cnt == 16'(FRAME_US - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= PWM_OFF;
            presc  <= '0;
            us_cnt <= '0;
            fs_q   <= 1'b0;
        end else begin
            case (state)
                PWM_OFF: begin
                    presc  <= '0;
                    us_cnt <= '0;
                    fs_q   <= bus.enable;
                    if (bus.enable) begin
                        state <= PWM_RUN;
                    end
                end
                PWM_RUN: begin
                    // enable is only honoured at a frame boundary so pulses are never cut short
                    fs_q <= frame_end && bus.enable;
                    if (us_tick) begin
                        presc  <= '0;
                        us_cnt <= frame_end ? '0 : us_cnt + 16'd1;
                    end else begin
                        presc <= presc + 1'b1;
                    end
                    if (frame_end && !bus.enable) begin
                        state <= PWM_OFF;
                    end
                end
                default: state <= PWM_OFF;
            endcase
        end
    end

    servo_channel #(
        .MIN_PULSE_US(MIN_PULSE_US), .US_PER_STEP(US_PER_STEP),
        .POS_MAX(POS_MAX), .POS_RESET(POS_RESET), .MAX_STEP(MAX_STEP)
    ) u_ch_x (
        .clk(clk), .rst(rst), .frame_end(frame_end), .run(run), .us_cnt(us_cnt),
        .pos(bus.pos_x), .pwm(pwm_x), .cur(cur_x)
    );

    servo_channel #(
        .MIN_PULSE_US(MIN_PULSE_US), .US_PER_STEP(US_PER_STEP),
        .POS_MAX(POS_MAX), .POS_RESET(POS_RESET), .MAX_STEP(MAX_STEP)
    ) u_ch_y (
        .clk(clk), .rst(rst), .frame_end(frame_end), .run(run), .us_cnt(us_cnt),
        .pos(bus.pos_y), .pwm(pwm_y), .cur(cur_y)
    );

    servo_channel #(
        .MIN_PULSE_US(MIN_PULSE_US), .US_PER_STEP(US_PER_STEP),
        .POS_MAX(POS_MAX), .POS_RESET(POS_RESET), .MAX_STEP(MAX_STEP)
    ) u_ch_z (
        .clk(clk), .rst(rst), .frame_end(frame_end), .run(run), .us_cnt(us_cnt),
        .pos(bus.pos_z), .pwm(pwm_z), .cur(cur_z)
    );

    assign bus.pwm_x       = pwm_x;
    assign bus.pwm_y       = pwm_y;
    assign bus.pwm_z       = pwm_z;
    assign bus.cur_x       = cur_x;
    assign bus.cur_y       = cur_y;
    assign bus.cur_z       = cur_z;
    assign bus.frame_start = fs_q;
    // held low while reset is asserted; otherwise a live compare in any state
    assign bus.settled     = rst
                             && (cur_x == clamp_pos(bus.pos_x, 8'(POS_MAX)))
                             && (cur_y == clamp_pos(bus.pos_y, 8'(POS_MAX)))
                             && (cur_z == clamp_pos(bus.pos_z, 8'(POS_MAX)));

endmodule
